// File: rtl/hmm_pkg.sv
// Shared PairHMM definitions: loader FSM states and base encodings.
// Also imported by the PairHMM diagonal array.
package hmm_pkg;

  typedef enum logic [2:0] {
    S_LOAD_RD,
    S_LOAD_HAP,
    S_ISSUE,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } hmm_state_e;

  localparam logic [2:0] BASE_A = 3'd0;
  localparam logic [2:0] BASE_C = 3'd1;
  localparam logic [2:0] BASE_G = 3'd2;
  localparam logic [2:0] BASE_T = 3'd3;
  localparam logic [2:0] BASE_N = 3'b100;

endpackage

// File: rtl/hmm_seq_buf.sv
// Depth x width register file. Writes append at the current count, and writes
// past DEPTH are dropped. All entries are visible on a flattened read port.
module hmm_seq_buf #(
  parameter int DEPTH = 16,
  parameter int W     = 11,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [W-1:0]       wr_data,
  output logic [CW-1:0]      cnt,
  output logic [DEPTH*W-1:0] rd_flat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [CW-1:0] r_cnt;
  logic          w_wr;

  assign w_wr = wr_en && (r_cnt < CW'(DEPTH));
  assign cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) r_cnt <= '0;
    else if (w_wr)     r_cnt <= r_cnt + CW'(1);
  end

  // Contents need no reset; the count defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_cnt[AW-1:0]] <= wr_data;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_rd
    assign rd_flat[i*W +: W] = r_mem[i];
  end

endmodule

// File: rtl/hmm_seq_loader.sv
// PairHMM feeder: buffers one read/haplotype pair, broadcasts the read to the PEs,
// then streams the haplotype and the flush bubbles. Optional macro: HMM_LOADER_LENCHK_EN.
module hmm_seq_loader
  import hmm_pkg::*;
#(
  parameter int NPE    = 16,
  parameter int HMAX   = 64,
  parameter int BASE_W = 3,
  parameter int QUAL_W = 8
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BASE_W-1:0]          in_base,
  input  logic [QUAL_W-1:0]          in_qual,
  input  logic                       in_last,
  output logic                       pe_load,
  output logic [NPE*BASE_W-1:0]      pe_rd_base,
  output logic [NPE*QUAL_W-1:0]      pe_rd_qual,
  output logic [$clog2(NPE+1)-1:0]   pe_rd_len,
  output logic                       hap_valid,
  input  logic                       hap_ready,
  output logic [BASE_W-1:0]          hap_base,
  output logic                       hap_first,
  output logic                       hap_last,
  output logic                       pair_done,
  output logic                       err_len
);

  localparam int LW = $clog2(NPE+1);
  localparam int HW = $clog2(HMAX+1);
  localparam int RW = BASE_W + QUAL_W;
  localparam logic [BASE_W-1:0] PAD = BASE_W'(BASE_N);

  hmm_state_e r_state, w_state_nxt;

  logic                   w_acc, w_last_acc, w_drop, w_clr;
  logic                   w_idx_end, w_fl_end, w_no_flush;
  logic [LW-1:0]          w_rd_cnt;
  logic [HW-1:0]          w_hap_cnt;
  logic [NPE*RW-1:0]      w_rd_flat;
  logic [HMAX*BASE_W-1:0] w_hap_flat;
  logic [HW-1:0]          r_idx;
  logic [LW-1:0]          r_fl_cnt;
  logic [NPE*BASE_W-1:0]  r_pe_base, w_pe_base;
  logic [NPE*QUAL_W-1:0]  r_pe_qual, w_pe_qual;
  logic [LW-1:0]          r_pe_len;

  assign in_ready   = (r_state == S_LOAD_RD) || (r_state == S_LOAD_HAP);
  assign w_acc      = in_valid && in_ready;
  assign w_last_acc = w_acc && in_last;

  // A dropped pair clears its partial buffers on the same edge it leaves LOAD_HAP.
  assign w_clr = (r_state == S_DONE) ||
                 ((r_state == S_LOAD_HAP) && w_last_acc && w_drop);

  hmm_seq_buf #(.DEPTH(NPE), .W(RW)) u_rd_buf (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .clr     (w_clr),
    .wr_en   (w_acc && (r_state == S_LOAD_RD)),
    .wr_data ({in_base, in_qual}),
    .cnt     (w_rd_cnt),
    .rd_flat (w_rd_flat)
  );

  hmm_seq_buf #(.DEPTH(HMAX), .W(BASE_W)) u_hap_buf (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .clr     (w_clr),
    .wr_en   (w_acc && (r_state == S_LOAD_HAP)),
    .wr_data (in_base),
    .cnt     (w_hap_cnt),
    .rd_flat (w_hap_flat)
  );

`ifdef HMM_LOADER_LENCHK_EN
  // Every sequence carries at least its in_last symbol, so only overflow can occur here.
  logic r_drop, r_err, w_ovf;

  assign w_ovf = w_acc &&
                 (((r_state == S_LOAD_RD)  && (w_rd_cnt  == LW'(NPE))) ||
                  ((r_state == S_LOAD_HAP) && (w_hap_cnt == HW'(HMAX))));
  assign w_drop  = r_drop || w_ovf;
  assign err_len = r_err;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_drop <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_ovf) r_err <= 1'b1;
      if ((r_state == S_LOAD_HAP) && w_last_acc) r_drop <= 1'b0;
      else if (w_ovf)                            r_drop <= 1'b1;
    end
  end
`else
  assign w_drop  = 1'b0;
  assign err_len = 1'b0;
`endif

  assign w_idx_end  = (r_idx == w_hap_cnt - HW'(1));
  assign w_fl_end   = (r_fl_cnt == r_pe_len - LW'(2));
  assign w_no_flush = (r_pe_len == LW'(1));

  always_comb begin
    w_state_nxt = r_state;
    pe_load     = 1'b0;
    pair_done   = 1'b0;
    hap_valid   = 1'b0;
    hap_base    = PAD;
    hap_first   = 1'b0;
    hap_last    = 1'b0;
    case (r_state)
      S_LOAD_RD:  if (w_last_acc) w_state_nxt = S_LOAD_HAP;
      S_LOAD_HAP: if (w_last_acc) w_state_nxt = w_drop ? S_LOAD_RD : S_ISSUE;
      S_ISSUE: begin
        pe_load     = 1'b1;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        hap_valid = 1'b1;
        hap_base  = w_hap_flat[r_idx*BASE_W +: BASE_W];
        hap_first = (r_idx == '0);
        // With a single-base read there is no flush, so the last base ends the pair.
        hap_last  = w_idx_end && w_no_flush;
        if (hap_ready && w_idx_end) w_state_nxt = w_no_flush ? S_DONE : S_FLUSH;
      end
      S_FLUSH: begin
        hap_valid = 1'b1;
        hap_last  = w_fl_end;
        if (hap_ready && w_fl_end) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        pair_done   = 1'b1;
        w_state_nxt = S_LOAD_RD;
      end
      default: w_state_nxt = S_LOAD_RD;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) r_state <= S_LOAD_RD;
    else            r_state <= w_state_nxt;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || (r_state == S_DONE)) begin
      r_idx    <= '0;
      r_fl_cnt <= '0;
    end else begin
      if ((r_state == S_STREAM) && hap_ready) r_idx    <= r_idx + HW'(1);
      if ((r_state == S_FLUSH)  && hap_ready) r_fl_cnt <= r_fl_cnt + LW'(1);
    end
  end

  // Unused PE slots get N / quality 0 so they never score.
  always_comb begin
    w_pe_base = '0;
    w_pe_qual = '0;
    for (int i = 0; i < NPE; i++) begin
      if (i < int'(w_rd_cnt)) begin
        w_pe_base[i*BASE_W +: BASE_W] = w_rd_flat[i*RW + QUAL_W +: BASE_W];
        w_pe_qual[i*QUAL_W +: QUAL_W] = w_rd_flat[i*RW +: QUAL_W];
      end else begin
        w_pe_base[i*BASE_W +: BASE_W] = PAD;
      end
    end
  end

  // Captured on the edge entering ISSUE so the values are already valid during pe_load.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_pe_base <= {NPE{PAD}};
      r_pe_qual <= '0;
      r_pe_len  <= '0;
    end else if ((r_state == S_LOAD_HAP) && (w_state_nxt == S_ISSUE)) begin
      r_pe_base <= w_pe_base;
      r_pe_qual <= w_pe_qual;
      r_pe_len  <= w_rd_cnt;
    end
  end

  assign pe_rd_base = r_pe_base;
  assign pe_rd_qual = r_pe_qual;
  assign pe_rd_len  = r_pe_len;

endmodule
